// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch stage, instruction memory, decode and retire.
// The fetch unit takes the master view and its environment takes the slave view.
interface fetch_unit_if;
   logic        jump_valid;
   logic [31:0] jump_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [3:0]  out_tag;
   logic        out_ready;

   modport master (
      input  jump_valid, jump_pc, imem_ack, imem_data, out_ready,
      output imem_req, imem_addr, out_valid, out_instr, out_pc, out_tag
   );

   modport slave (
      output jump_valid, jump_pc, imem_ack, imem_data, out_ready,
      input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_tag
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding word read, a small tagged instruction queue,
// and retire-driven redirects that bump the tag so wrong-path work is killed downstream.
module fetch_unit #(
   parameter logic [31:0] START_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.master bus
);
   localparam int             PTR_W      = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);
   localparam logic [0:0]     FETCH      = 1'b0;
   localparam logic [0:0]     DISCARD    = 1'b1;

   logic [0:0]       state;
   logic [31:0]      pc;
   logic [31:0]      held_addr;
   logic [3:0]       tag;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic [31:0]      q_instr [DEPTH];
   logic [31:0]      q_pc    [DEPTH];
   logic [3:0]       q_tag   [DEPTH];
   logic             ack_taken;
   logic             push;
   logic             pop;

   // Request is gated by reset so it drops the instant reset asserts mid-transaction.
   always_comb begin
      bus.imem_req = 1'b0;
      if (reset)
         bus.imem_req = (state == DISCARD) || (count < FULL_COUNT);
   end

   assign bus.imem_addr = (state == DISCARD) ? held_addr : pc;
   assign bus.out_valid = (count != '0);
   assign bus.out_instr = q_instr[rd_ptr];
   assign bus.out_pc    = q_pc[rd_ptr];
   assign bus.out_tag   = q_tag[rd_ptr];

   assign ack_taken = bus.imem_req && bus.imem_ack;
   assign push      = (state == FETCH) && ack_taken && !bus.jump_valid;
   assign pop       = bus.out_valid && bus.out_ready;

   // Control: a redirect while a read is in flight parks on the old address until it retires.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= FETCH;
         pc        <= START_PC & 32'hFFFF_FFFC;
         held_addr <= 32'h0;
         tag       <= 4'h0;
      end else if (bus.jump_valid) begin
         tag <= tag + 4'd1;
         pc  <= bus.jump_pc & 32'hFFFF_FFFC;
         if (state == FETCH) begin
            if (bus.imem_req && !bus.imem_ack) begin
               state     <= DISCARD;
               held_addr <= pc;
            end
         end else if (bus.imem_ack) begin
            state <= FETCH;
         end
      end else begin
         if (push)
            pc <= pc + 32'd4;
         if ((state == DISCARD) && bus.imem_ack)
            state <= FETCH;
      end
   end

   // Queue bookkeeping; a flush overrides any same-cycle push or pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (bus.jump_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            count <= count + (PTR_W+1)'(1);
         else if (!push && pop)
            count <= count - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_instr[i] <= 32'h0;
            q_pc[i]    <= 32'h0;
            q_tag[i]   <= 4'h0;
         end
      end else if (push) begin
         q_instr[wr_ptr] <= bus.imem_data;
         q_pc[wr_ptr]    <= pc;
         q_tag[wr_ptr]   <= tag;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue-level reference model plus a variable-latency
// memory, compared against the DUT outputs every cycle on the falling edge.
module tb_fetch_unit;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] START_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [3:0]  tag;
   } entry_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   testCount = 0;
   int   failCount = 0;

   entry_t      m_q[$];
   logic [31:0] m_pc;
   logic [3:0]  m_tag;
   logic        m_discard;
   logic [31:0] m_held;
   int          memWait;

   fetch_unit_if bus();

   fetch_unit #(.START_PC(START_PC), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, observed, expected, $time);
      end
   endtask

   function automatic void resetModel();
      m_q.delete();
      m_pc      = START_PC;
      m_tag     = 4'h0;
      m_discard = 1'b0;
      m_held    = 32'h0;
      memWait   = -1;
   endfunction

   function automatic logic modelReq();
      return m_discard ? 1'b1 : (m_q.size() < DEPTH);
   endfunction

   function automatic logic [31:0] modelAddr();
      return m_discard ? m_held : m_pc;
   endfunction

   // One cycle: check outputs, pick inputs, advance the model, let the posedge happen.
   task automatic applyStimulus(input int pJump, input int pReady, input int maxLat, input int pcMode);
      logic        req, ack, jump, ready;
      logic [31:0] addr, jpc, data;
      entry_t      e;
      @(negedge clk);
      req  = modelReq();
      addr = modelAddr();
      checkOutput("imem_req", {31'b0, bus.imem_req}, {31'b0, req});
      if (req)
         checkOutput("imem_addr", bus.imem_addr, addr);
      checkOutput("out_valid", {31'b0, bus.out_valid}, {31'b0, (m_q.size() != 0)});
      if (m_q.size() != 0) begin
         checkOutput("out_instr", bus.out_instr, m_q[0].instr);
         checkOutput("out_pc", bus.out_pc, m_q[0].pc);
         checkOutput("out_tag", {28'b0, bus.out_tag}, {28'b0, m_q[0].tag});
      end

      ack = 1'b0;
      if (req) begin
         if (memWait < 0)
            memWait = $urandom_range(maxLat, 0);
         if (memWait == 0) begin
            ack     = 1'b1;
            memWait = -1;
         end else begin
            memWait--;
         end
      end
      data  = ack ? addr + 32'h100 : $urandom;
      jump  = ($urandom_range(99, 0) < pJump);
      ready = ($urandom_range(99, 0) < pReady);
      case (pcMode)
         1:       jpc = 32'h0000_0103;
         2:       jpc = 32'hFFFF_FFF5;
         3:       jpc = 32'h0000_0200;
         default: jpc = $urandom;
      endcase

      bus.imem_ack   = ack;
      bus.imem_data  = data;
      bus.jump_valid = jump;
      bus.jump_pc    = jump ? jpc : $urandom;
      bus.out_ready  = ready;

      if (jump) begin
         m_tag = m_tag + 4'd1;
         m_q.delete();
         if (!m_discard) begin
            if (req && !ack) begin
               m_discard = 1'b1;
               m_held    = m_pc;
            end
         end else if (ack) begin
            m_discard = 1'b0;
         end
         m_pc = {jpc[31:2], 2'b00};
      end else begin
         if (m_q.size() != 0 && ready)
            void'(m_q.pop_front());
         if (m_discard) begin
            if (ack)
               m_discard = 1'b0;
         end else if (ack) begin
            e.instr = data;
            e.pc    = m_pc;
            e.tag   = m_tag;
            m_q.push_back(e);
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic resetMidRequest();
      int guard = 0;
      while (memWait <= 0 && guard < 40) begin
         applyStimulus(0, 50, 3, 0);
         guard++;
      end
      checkOutput("pending_before_reset", {31'b0, (memWait > 0)}, 32'h1);
      @(negedge clk);
      bus.imem_ack   = 1'b0;
      bus.jump_valid = 1'b0;
      reset = 1'b0;
      #1;
      checkOutput("reset_req", {31'b0, bus.imem_req}, 32'h0);
      checkOutput("reset_valid", {31'b0, bus.out_valid}, 32'h0);
      repeat (2) @(negedge clk);
      resetModel();
      reset = 1'b1;
   endtask

   initial begin
      bus.jump_valid = 1'b0;
      bus.jump_pc    = 32'h0;
      bus.imem_ack   = 1'b0;
      bus.imem_data  = 32'h0;
      bus.out_ready  = 1'b0;
      resetModel();
      #1;
      checkOutput("rst_imem_req", {31'b0, bus.imem_req}, 32'h0);
      checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
      checkOutput("rst_out_instr", bus.out_instr, 32'h0);
      checkOutput("rst_out_pc", bus.out_pc, 32'h0);
      checkOutput("rst_out_tag", {28'b0, bus.out_tag}, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      repeat (20) applyStimulus(0, 100, 0, 0);
      repeat (10) applyStimulus(0, 0, 0, 0);
      checkOutput("full_count", m_q.size(), DEPTH);
      applyStimulus(0, 100, 0, 0);
      repeat (4) applyStimulus(0, 0, 0, 0);
      applyStimulus(100, 0, 0, 3);
      repeat (10) applyStimulus(0, 100, 0, 0);

      repeat (40) applyStimulus(15, 70, 3, 0);
      repeat (16) applyStimulus(100, 100, 0, 1);
      repeat (10) applyStimulus(0, 100, 1, 0);
      applyStimulus(100, 100, 0, 2);
      repeat (10) applyStimulus(0, 100, 0, 0);

      resetMidRequest();
      repeat (10) applyStimulus(0, 100, 0, 0);

      repeat (2000) applyStimulus(10, 70, 3, 0);
      repeat (500) applyStimulus(30, 40, 3, 2);
      resetMidRequest();
      repeat (200) applyStimulus(5, 60, 2, 0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end
endmodule
